// File: rtl/muldiv_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// muldiv_ctrl_pkg
//   Shared definitions for the E-stage multiply/divide sequencer. Decode
//   drives Op with these encodings and Hazard uses them to classify
//   mult/div/mfhi/mflo/mthi/mtlo instructions.
//
//   Contents:
//     MD_*            3-bit operation encodings (6-7 reserved, no-op)
//     md_state_e      sequencer state encoding (S_IDLE, S_RUN)
//     DEF_*_CYCLES    default busy latencies
//     is_long_op()    true for ops that occupy the sequencer (mult/div)
//     max_int()       constant-friendly max, used for counter sizing
// ---------------------------------------------------------------------------
package muldiv_ctrl_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } md_state_e;

  function automatic logic is_long_op(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) ||
           (op == MD_DIV)  || (op == MD_DIVU);
  endfunction

  function automatic int max_int(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

endpackage

// File: rtl/muldiv_arith.sv
// ---------------------------------------------------------------------------
// muldiv_arith
//   Purely combinational datapath for the multiply/divide sequencer. It works
//   on the operands latched at Start, so its result is stable for the whole
//   busy window and only sampled by muldiv_ctrl on the commit edge.
//
//   Ports:
//     a, b         in   32  latched rs / rt operands
//     op           in   3   latched operation (MD_* encoding)
//     hi_next      out  32  value HI should take at commit
//     lo_next      out  32  value LO should take at commit
//     div_by_zero  out  1   divide op with b == 0; HI/LO must be kept
// ---------------------------------------------------------------------------
module muldiv_arith
  import muldiv_ctrl_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  op,
  output logic [31:0] hi_next,
  output logic [31:0] lo_next,
  output logic        div_by_zero
);

  logic [63:0] a_sx;
  logic [63:0] b_sx;
  logic [63:0] prod_s;
  logic [63:0] prod_u;

  logic        b_zero;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] safe_mag_b;
  logic [31:0] safe_b;
  logic [31:0] quo_mag;
  logic [31:0] rem_mag;
  logic [31:0] quo_s;
  logic [31:0] rem_s;
  logic [31:0] quo_u;
  logic [31:0] rem_u;

  // Sign-extending both operands to 64 bits makes the low 64 bits of an
  // ordinary product equal to the full signed product.
  assign a_sx   = {{32{a[31]}}, a};
  assign b_sx   = {{32{b[31]}}, b};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Signed divide is done on magnitudes, then the signs are restored:
  // quotient is negative when operand signs differ (truncation toward zero),
  // remainder follows the dividend. 0x80000000 / -1 falls out naturally:
  // |a| = 0x80000000, quotient magnitude 0x80000000, negated back to itself,
  // remainder 0.
  assign b_zero     = (b == 32'd0);
  assign mag_a      = a[31] ? (32'd0 - a) : a;
  assign mag_b      = b[31] ? (32'd0 - b) : b;
  // Substitute a divisor of 1 on divide-by-zero so the dividers never
  // produce X; the result is discarded via div_by_zero anyway.
  assign safe_mag_b = b_zero ? 32'd1 : mag_b;
  assign safe_b     = b_zero ? 32'd1 : b;

  assign quo_mag = mag_a / safe_mag_b;
  assign rem_mag = mag_a % safe_mag_b;
  assign quo_s   = (a[31] ^ b[31]) ? (32'd0 - quo_mag) : quo_mag;
  assign rem_s   = a[31] ? (32'd0 - rem_mag) : rem_mag;

  assign quo_u = a / safe_b;
  assign rem_u = a % safe_b;

  // Result select; MTHI/MTLO and reserved ops never reach commit, so they
  // simply yield zeros here.
  always_comb begin
    hi_next     = 32'd0;
    lo_next     = 32'd0;
    div_by_zero = 1'b0;
    case (op)
      MD_MULT: begin
        hi_next = prod_s[63:32];
        lo_next = prod_s[31:0];
      end
      MD_MULTU: begin
        hi_next = prod_u[63:32];
        lo_next = prod_u[31:0];
      end
      MD_DIV: begin
        hi_next     = rem_s;
        lo_next     = quo_s;
        div_by_zero = b_zero;
      end
      MD_DIVU: begin
        hi_next     = rem_u;
        lo_next     = quo_u;
        div_by_zero = b_zero;
      end
      default: begin
        hi_next     = 32'd0;
        lo_next     = 32'd0;
        div_by_zero = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// ---------------------------------------------------------------------------
// muldiv_ctrl
//   Multi-cycle multiply/divide sequencer for the E stage. A Start pulse in
//   IDLE with a mult/div op latches the operands and holds Busy for a fixed
//   latency, then commits the result into the architectural HI/LO registers
//   on the same edge Busy falls. MTHI/MTLO write HI/LO directly in one cycle.
//   Hazard stalls dependent instructions in D while Start|Busy, so a Start
//   arriving during RUN is simply ignored.
//
//   Parameters:
//     MULT_CYCLES  busy cycles for MULT/MULTU (>= 1)
//     DIV_CYCLES   busy cycles for DIV/DIVU   (>= 1)
//
//   Ports:
//     clk    in   1   clock, rising edge
//     reset  in   1   synchronous, active-high; discards any in-flight op
//     Start  in   1   one-cycle request, sampled only in IDLE
//     Op     in   3   MD_* operation
//     A      in   32  rs operand
//     B      in   32  rt operand
//     Busy   out  1   mult/div in flight (registered)
//     HI     out  32  architectural HI (registered)
//     LO     out  32  architectural LO (registered)
// ---------------------------------------------------------------------------
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
)
(
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int CNT_W = $clog2(max_int(MULT_CYCLES, DIV_CYCLES) + 1);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  md_state_e        state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      a_q;
  logic [31:0]      b_q;
  logic [2:0]       op_q;

  logic [31:0]      hi_next;
  logic [31:0]      lo_next;
  logic             div_by_zero;

  muldiv_arith u_arith (
    .a           (a_q),
    .b           (b_q),
    .op          (op_q),
    .hi_next     (hi_next),
    .lo_next     (lo_next),
    .div_by_zero (div_by_zero)
  );

  // Sequencer. The counter is loaded with the latency N when Start is
  // accepted, so Busy covers exactly N cycles: the commit fires on the edge
  // where the counter reads 1, which is the same edge that drops Busy and
  // returns to IDLE. That lets a new Start be accepted in the first cycle
  // Busy reads 0. Operands are latched so the forwarded A/B may change
  // freely while the op is in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      Busy  <= 1'b0;
      HI    <= 32'd0;
      LO    <= 32'd0;
      cnt   <= '0;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
      op_q  <= 3'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (Start) begin
            if (is_long_op(Op)) begin
              a_q   <= A;
              b_q   <= B;
              op_q  <= Op;
              cnt   <= ((Op == MD_DIV) || (Op == MD_DIVU)) ? DIV_LOAD : MULT_LOAD;
              state <= S_RUN;
              Busy  <= 1'b1;
            end else if (Op == MD_MTHI) begin
              HI <= A;
            end else if (Op == MD_MTLO) begin
              LO <= A;
            end
          end
        end

        S_RUN: begin
          if (cnt == CNT_ONE) begin
            // Divide-by-zero keeps the previous HI/LO rather than loading
            // a meaningless result.
            if (!div_by_zero) begin
              HI <= hi_next;
              LO <= lo_next;
            end
            cnt   <= '0;
            state <= S_IDLE;
            Busy  <= 1'b0;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end

        default: begin
          state <= S_IDLE;
          Busy  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// ---------------------------------------------------------------------------
// tb_muldiv_ctrl
//   Directed bench for muldiv_ctrl. Inputs change and outputs are sampled on
//   the falling edge; the DUT acts on the rising edge.
// ---------------------------------------------------------------------------
module tb_muldiv_ctrl;
  import muldiv_ctrl_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int vector_count = 0;
  int miscompare_count = 0;

  muldiv_ctrl #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .Start (start),
    .Op    (op),
    .A     (a),
    .B     (b),
    .Busy  (busy),
    .HI    (hi),
    .LO    (lo)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every vector and reports miscompares.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    vector_count++;
    if (actual !== expected) begin
      miscompare_count++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Called at a falling edge: holds Start for one cycle and returns at the
  // next falling edge, i.e. the first cycle after the request was sampled.
  task automatic applyStimulus(input logic [2:0] op_i, input logic [31:0] a_i,
                               input logic [31:0] b_i);
    start = 1'b1;
    op    = op_i;
    a     = a_i;
    b     = b_i;
    @(negedge clk);
    start = 1'b0;
    a     = 32'hDEAD_BEEF;
    b     = 32'hDEAD_BEEF;
  endtask

  // Counts falling edges at which Busy is high, bounded so a stuck Busy
  // shows up as a wrong busy length instead of a hang.
  task automatic waitIdle(output int cycles);
    cycles = 0;
    while (busy === 1'b1 && cycles < 100) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic runOp(input string tag, input logic [2:0] op_i,
                       input logic [31:0] a_i, input logic [31:0] b_i,
                       input int n, input logic [31:0] exp_hi,
                       input logic [31:0] exp_lo);
    int cycles;
    applyStimulus(op_i, a_i, b_i);
    waitIdle(cycles);
    checkOutput({tag, "_busy_len"}, 32'(cycles), 32'(n));
    checkOutput({tag, "_hi"}, hi, exp_hi);
    checkOutput({tag, "_lo"}, lo, exp_lo);
  endtask

  initial begin
    int cycles;
    reset = 1'b1;
    start = 1'b0;
    op    = 3'd0;
    a     = 32'd0;
    b     = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    $display("[TB] reset state");
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_hi", hi, 32'd0);
    checkOutput("rst_lo", lo, 32'd0);

    $display("[TB] multiply and divide vectors");
    runOp("mult_neg", MD_MULT, 32'hFFFF_FFFE, 32'h0000_0003, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    // back-to-back: each runOp starts in the first cycle Busy reads 0
    runOp("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h0000_0001);
    runOp("div_neg", MD_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    runOp("div_negdivisor", MD_DIV, 32'h0000_0007, 32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD);
    runOp("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000);
    runOp("divu_big", MD_DIVU, 32'hFFFF_FFF9, 32'h0000_0002, 10, 32'h0000_0001, 32'h7FFF_FFFC);

    $display("[TB] MTHI/MTLO then divide by zero");
    applyStimulus(MD_MTHI, 32'h0000_0011, 32'd0);
    checkOutput("mthi_hi", hi, 32'h0000_0011);
    checkOutput("mthi_busy", {31'd0, busy}, 32'd0);
    applyStimulus(MD_MTLO, 32'h0000_0022, 32'd0);
    checkOutput("mtlo_lo", lo, 32'h0000_0022);
    checkOutput("mtlo_hi", hi, 32'h0000_0011);
    checkOutput("mtlo_busy", {31'd0, busy}, 32'd0);
    runOp("divu_zero", MD_DIVU, 32'h0000_1234, 32'h0000_0000, 10, 32'h0000_0011, 32'h0000_0022);
    runOp("div_zero", MD_DIV, 32'h8000_0000, 32'h0000_0000, 10, 32'h0000_0011, 32'h0000_0022);

    $display("[TB] Start during RUN is ignored");
    applyStimulus(MD_DIV, 32'd100, 32'd7);   // now in busy cycle 1
    repeat (2) @(negedge clk);               // busy cycle 3
    start = 1'b1;
    op    = MD_MTLO;
    a     = 32'h0000_0055;
    b     = 32'd0;
    @(negedge clk);                          // busy cycle 4
    start = 1'b0;
    checkOutput("run_start_lo", lo, 32'h0000_0022);
    checkOutput("run_start_hi", hi, 32'h0000_0011);
    checkOutput("run_start_busy", {31'd0, busy}, 32'd1);
    waitIdle(cycles);
    checkOutput("run_start_busy_len", 32'(cycles + 3), 32'd10);
    checkOutput("run_start_final_lo", lo, 32'd14);
    checkOutput("run_start_final_hi", hi, 32'd2);

    $display("[TB] reset mid-operation");
    applyStimulus(MD_MULT, 32'd3, 32'd4);    // busy cycle 1
    repeat (2) @(negedge clk);               // busy cycle 3
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
    checkOutput("midrst_hi", hi, 32'd0);
    checkOutput("midrst_lo", lo, 32'd0);
    runOp("after_rst", MD_MULTU, 32'd6, 32'd7, 5, 32'd0, 32'd42);

    $display("[TB] reserved op");
    applyStimulus(3'd6, 32'h0000_0099, 32'h0000_0001);
    checkOutput("rsvd_busy", {31'd0, busy}, 32'd0);
    checkOutput("rsvd_hi", hi, 32'd0);
    checkOutput("rsvd_lo", lo, 32'd42);
    applyStimulus(3'd7, 32'h0000_0099, 32'h0000_0001);
    checkOutput("rsvd7_busy", {31'd0, busy}, 32'd0);
    checkOutput("rsvd7_lo", lo, 32'd42);

    $display("== %0d vectors applied, %0d miscompares ==", vector_count, miscompare_count);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Multi-cycle multiply/divide sequencer for the E stage of the 5-stage pipeline.
- Accepts a `Start` pulse with an opcode and operands, and asserts `Busy` for a fixed per-op latency. It then commits results to the architectural HI/LO registers.
- Its `Start`/`Busy` pair feeds the Hazard unit, which stalls any mult/div/mfhi/mflo/mthi/mtlo in D while `Start|Busy`.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (must be >=1)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (must be >=1)

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- Start  input  1  one-cycle request; qualified by Op, sampled only in IDLE
- Op  input  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 reserved (no-op)
- A  input  32  rs operand (already forwarded)
- B  input  32  rt operand (already forwarded)
- Busy  output  1  high while a mult/div is in flight
- HI  output  32  architectural HI register
- LO  output  32  architectural LO register

Behaviour:
- Clock and reset:
  - One clock: clk.
  - reset is synchronous and active-high.
  - Reset (any state, including mid-operation): state=IDLE, Busy=0, HI=0, LO=0, counter=0, operand/op latches cleared. The in-flight result is discarded.
- States: IDLE, RUN.
- IDLE, Start=1, Op in {MULT,MULTU,DIV,DIVU}:
  - Latch A, B and Op.
  - Load counter with MULT_CYCLES or DIV_CYCLES.
  - Go to RUN.
- Timing:
  - Start high in cycle t -> Busy=1 in cycles t+1 .. t+N (N = latency); Busy=0 at t+N+1.
  - HI/LO take the new values on the edge ending cycle t+N, so they are visible at t+N+1, coincident with Busy falling.
- RUN: counter decrements each cycle. When counter==1, commit HI/LO and return to IDLE.
- Back-to-back: Start may be asserted in the cycle Busy first reads 0; it is accepted normally.
- MTHI/MTLO:
  - Accepted only in IDLE with Start=1.
  - A is written to HI (MTHI) or LO (MTLO) on that same edge, visible at t+1.
  - Busy stays 0; no state change.
- Start while in RUN: ignored entirely (Hazard guarantees it never occurs). The bench checks that HI/LO and the counter are unaffected.
- Reserved Op with Start: ignored.
- Arithmetic (computed from the latched operands):
  - MULT: {HI,LO} = signed(A)*signed(B), full 64 bits.
  - MULTU: same, unsigned.
  - DIV: LO = quotient truncated toward zero; HI = remainder, which takes the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
  - Signed overflow 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0x00000000.
- Divide by zero (B==0, DIV or DIVU):
  - Busy is still asserted for DIV_CYCLES.
  - HI and LO are left unchanged at commit; never X.
- Outputs HI, LO and Busy are registered; there is no combinational path from inputs to outputs.
- Counter width: $clog2(max(MULT_CYCLES,DIV_CYCLES)+1).

Decomposition:
- Shared package/header (muldiv_defs):
  - Op encodings MD_MULT..MD_MTLO.
  - State encodings S_IDLE, S_RUN.
  - Default latency constants.
  - Op encodings are also used by Decode to drive Op and by Hazard to classify instructions.
- One sub-module, muldiv_arith: purely combinational.
  - Inputs: latched A, B, Op.
  - Outputs: hi_next, lo_next and a div_by_zero flag, covering the signed/unsigned, overflow and zero cases.
  - muldiv_ctrl keeps the FSM, counter and HI/LO registers.

Test Plan:
- Reset then MULT: A=0xFFFFFFFE (-2), B=0x00000003. Required: Busy high exactly 5 cycles; at t+6 HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU: A=0xFFFFFFFF, B=0xFFFFFFFF. Required: after 5 busy cycles HI=0xFFFFFFFE, LO=0x00000001.
- DIV signed: A=0xFFFFFFF9 (-7), B=0x00000002. Required: Busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV overflow: A=0x80000000, B=0xFFFFFFFF. Required: LO=0x80000000, HI=0.
- DIVU by zero after preloading HI=0x11 via MTHI and LO=0x22 via MTLO (each visible next cycle, Busy=0 throughout). Required: Busy 10 cycles, then HI=0x11, LO=0x22 unchanged.
- Mid-operation events: assert Start with MTLO A=0x55 during RUN of a DIV; required LO unaffected until commit, final LO is the DIV quotient. Separately, assert reset at busy cycle 3 of a MULT; required next cycle Busy=0, HI=LO=0, and a new Start is accepted.
